// File: rtl/cic_pkg.sv
// Shared constants and types for the CIC decimator back end (decimator + comb cascade).
package cic_pkg;

   localparam int unsigned DEF_IW = 19;
   localparam int unsigned DEF_OW = 19;
   localparam int unsigned DEF_R  = 16;
   localparam int unsigned DEF_M  = 1;
   localparam int unsigned DEF_N  = 1;

   localparam int unsigned CNT_W = $clog2(DEF_R);

   typedef logic signed [DEF_OW-1:0] sample_t;

   // Counter width for an arbitrary ratio; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned r);
      return (r < 2) ? 1 : $clog2(r);
   endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb: y[n] = x[n] - x[n-N], evaluated only on input strobes, wrapping arithmetic.
module cic_comb_stage
   import cic_pkg::*;
#(
   parameter int unsigned W = DEF_OW,
   parameter int unsigned N = DEF_N
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic signed [W-1:0] x_data,
   input  logic                x_ready,
   output logic signed [W-1:0] y_data,
   output logic                y_ready
);

   logic signed [W-1:0] dly [N];

   // Delay line and difference advance together, only when a decimated sample arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_data  <= '0;
         y_ready <= 1'b0;
         for (int i = 0; i < int'(N); i++) begin
            dly[i] <= '0;
         end
      end else begin
         y_ready <= x_ready;
         if (x_ready) begin
            y_data <= x_data - dly[N-1];
            dly[0] <= x_data;
            for (int i = 1; i < int'(N); i++) begin
               dly[i] <= dly[i-1];
            end
         end
      end
   end

endmodule

// File: rtl/cic_decim_comb.sv
// Integrator-less CIC back end: keep every R-th valid sample, then M cascaded combs.
module cic_decim_comb
   import cic_pkg::*;
#(
   parameter int unsigned IW = DEF_IW,
   parameter int unsigned OW = DEF_OW,
   parameter int unsigned R  = DEF_R,
   parameter int unsigned M  = DEF_M,
   parameter int unsigned N  = DEF_N
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic signed [IW-1:0] i_data,
   input  logic                 i_ready,
   output logic signed [OW-1:0] o_data,
   output logic                 o_ready
);

   localparam int unsigned CW = cnt_width(R);

   logic [CW-1:0]        cnt;
   logic signed [OW-1:0] x_ext;
   logic signed [OW-1:0] dec_data;
   logic                 dec_ready;

   logic signed [OW-1:0] st_data  [M+1];
   logic                 st_ready [M+1];

   assign x_ext = OW'(i_data);

   // Counts valid samples only; the R-th of each group is captured.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         cnt       <= '0;
         dec_data  <= '0;
         dec_ready <= 1'b0;
      end else begin
         dec_ready <= 1'b0;
         if (i_ready) begin
            if (cnt == CW'(R - 1)) begin
               cnt       <= '0;
               dec_data  <= x_ext;
               dec_ready <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   assign st_data[0]  = dec_data;
   assign st_ready[0] = dec_ready;

   genvar g;
   generate
      for (g = 0; g < int'(M); g++) begin : g_comb
         cic_comb_stage #(
            .W (OW),
            .N (N)
         ) u_stage (
            .clk     (i_clk),
            .rst_n   (i_reset),
            .x_data  (st_data[g]),
            .x_ready (st_ready[g]),
            .y_data  (st_data[g+1]),
            .y_ready (st_ready[g+1])
         );
      end
   endgenerate

   // Output register: o_data holds between strobes.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_data  <= '0;
         o_ready <= 1'b0;
      end else begin
         o_ready <= st_ready[M];
         if (st_ready[M]) begin
            o_data <= st_data[M];
         end
      end
   end

endmodule

// File: tb/tb_cic_decim_comb.sv
// Bench for cic_decim_comb: three configurations against a closed-form decimate-then-difference model.
module tb_cic_decim_comb;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic signed [18:0] a_di, a_do;
   logic               a_vi, a_vo;
   logic signed [7:0]  b_di, b_do;
   logic               b_vi, b_vo;
   logic signed [11:0] c_di;
   logic signed [13:0] c_do;
   logic               c_vi, c_vo;

   cic_decim_comb #(.IW(19), .OW(19), .R(4), .M(1), .N(1)) u_a (
      .i_clk(clk), .i_reset(rst_n), .i_data(a_di), .i_ready(a_vi), .o_data(a_do), .o_ready(a_vo));
   cic_decim_comb #(.IW(8), .OW(8), .R(2), .M(1), .N(1)) u_b (
      .i_clk(clk), .i_reset(rst_n), .i_data(b_di), .i_ready(b_vi), .o_data(b_do), .o_ready(b_vo));
   cic_decim_comb #(.IW(12), .OW(14), .R(2), .M(2), .N(1)) u_c (
      .i_clk(clk), .i_reset(rst_n), .i_data(c_di), .i_ready(c_vi), .o_data(c_do), .o_ready(c_vo));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int r_of(input int i);
      return (i == 0) ? 4 : 2;
   endfunction
   function automatic int m_of(input int i);
      return (i == 2) ? 2 : 1;
   endfunction
   function automatic int n_of(input int i);
      return (i < 0) ? 0 : 1;
   endfunction
   function automatic int ow_of(input int i);
      return (i == 0) ? 19 : ((i == 1) ? 8 : 14);
   endfunction

   function automatic longint wrap(input longint v, input int w);
      longint m, r;
      m = longint'(1) << w;
      r = v & (m - 1);
      if (r >= (m >>> 1)) r = r - m;
      return r;
   endfunction

   // Reference model: the decimated sequence x[j] and the M-fold difference in closed form,
   // sum_t (-1)^t C(M,t) x[j - t*N], reduced modulo 2^OW.
   typedef struct {
      int     inst;
      longint due;
      longint val;
   } pend_t;

   longint hist [3][4096];
   int     hcnt [3];
   int     gcnt [3];
   longint exp_val [3];
   bit     exp_rdy [3];
   pend_t  pq [$];
   longint cyc = 0;
   longint din [3];
   bit     vin [3];

   initial begin
      for (int i = 0; i < 3; i++) begin
         hcnt[i] = 0; gcnt[i] = 0; exp_val[i] = 0; exp_rdy[i] = 1'b0;
      end
   end

   function automatic longint comb_out(input int i);
      longint sum, coef;
      int j, idx;
      j = hcnt[i] - 1;
      sum = 0;
      coef = 1;
      for (int t = 0; t <= m_of(i); t++) begin
         idx = j - t * n_of(i);
         if (idx >= 0) sum += ((t % 2) ? -coef : coef) * hist[i][idx];
         coef = coef * (m_of(i) - t) / (t + 1);
      end
      return wrap(sum, ow_of(i));
   endfunction

   always @(posedge clk) begin
      din[0] = longint'(a_di); vin[0] = a_vi;
      din[1] = longint'(b_di); vin[1] = b_vi;
      din[2] = longint'(c_di); vin[2] = c_vi;
      cyc++;
      if (!rst_n) begin
         pq.delete();
         for (int i = 0; i < 3; i++) begin
            gcnt[i] = 0; hcnt[i] = 0; exp_val[i] = 0; exp_rdy[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 3; i++) exp_rdy[i] = 1'b0;
         for (int k = pq.size() - 1; k >= 0; k--) begin
            if (pq[k].due == cyc) begin
               exp_rdy[pq[k].inst] = 1'b1;
               exp_val[pq[k].inst] = pq[k].val;
               pq.delete(k);
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (vin[i]) begin
               if (gcnt[i] == r_of(i) - 1) begin
                  gcnt[i] = 0;
                  if (hcnt[i] < 4096) begin
                     hist[i][hcnt[i]] = din[i];
                     hcnt[i]++;
                     pq.push_back('{i, cyc + 1 + longint'(m_of(i)), comb_out(i)});
                  end
               end else begin
                  gcnt[i]++;
               end
            end
         end
      end
   end

   bit     run_chk = 1'b1;
   bit     a_prev = 1'b0, b_prev = 1'b0, c_prev = 1'b0;
   longint cap_a [$], cap_b [$], cap_c [$], cap_a_t [$];

   // Every-cycle comparison against the model, plus strobe spacing and output capture.
   always @(negedge clk) begin
      if (run_chk) begin
         chk("a_ready", longint'(a_vo), longint'(exp_rdy[0]));
         chk("a_data",  longint'(a_do), exp_val[0]);
         chk("b_ready", longint'(b_vo), longint'(exp_rdy[1]));
         chk("b_data",  longint'(b_do), exp_val[1]);
         chk("c_ready", longint'(c_vo), longint'(exp_rdy[2]));
         chk("c_data",  longint'(c_do), exp_val[2]);
         chk("a_back_to_back", longint'(a_vo && a_prev), 0);
         chk("b_back_to_back", longint'(b_vo && b_prev), 0);
         chk("c_back_to_back", longint'(c_vo && c_prev), 0);
         if (a_vo) begin cap_a.push_back(longint'(a_do)); cap_a_t.push_back(cyc); end
         if (b_vo) cap_b.push_back(longint'(b_do));
         if (c_vo) cap_c.push_back(longint'(c_do));
      end
      a_prev = a_vo; b_prev = b_vo; c_prev = c_vo;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_all();
      a_vi = 1'b0; b_vi = 1'b0; c_vi = 1'b0;
      a_di = '0;   b_di = '0;   c_di = '0;
   endtask

   task automatic clear_caps();
      cap_a.delete(); cap_b.delete(); cap_c.delete(); cap_a_t.delete();
   endtask

   task automatic chk_seq(input string name, input longint got [$], input longint want [$]);
      chk({name, "_count"}, longint'(got.size()), longint'(want.size()));
      for (int i = 0; i < want.size() && i < got.size(); i++) begin
         chk($sformatf("%s_%0d", name, i), got[i], want[i]);
      end
   endtask

   longint acc_t;
   longint w_a [$];
   longint w_b [$];
   longint w_c [$];
   longint bseq [4];

   initial begin
      // Reset held with valid data present: outputs stay zero.
      rst_n = 1'b0;
      a_vi = 1'b1; b_vi = 1'b1; c_vi = 1'b1;
      a_di = 19'sd5; b_di = 8'sd5; c_di = 12'sd5;
      repeat (4) begin
         tick();
         chk("rst_a_ready", longint'(a_vo), 0);
         chk("rst_a_data",  longint'(a_do), 0);
         chk("rst_c_data",  longint'(c_do), 0);
      end

      // Ramp on A, wrap pair on B, constant on C.
      rst_n = 1'b1;
      clear_caps();
      bseq[0] = -128; bseq[1] = 127; bseq[2] = 127; bseq[3] = -128;
      acc_t = 0;
      for (int k = 0; k < 16; k++) begin
         a_vi = 1'b1; a_di = 19'(k);
         b_vi = (k < 4); b_di = (k < 4) ? 8'(bseq[k]) : 8'sd0;
         c_vi = (k < 8); c_di = 12'sd10;
         tick();
         if (k == 3) acc_t = cyc;
      end
      idle_all();
      repeat (6) tick();
      w_a = '{3, 4, 4, 4};
      w_b = '{127, 1};
      w_c = '{10, -10, 0, 0};
      chk_seq("ramp_a", cap_a, w_a);
      chk_seq("wrap_b", cap_b, w_b);
      chk_seq("cascade_c", cap_c, w_c);
      if (cap_a_t.size() >= 2) begin
         chk("ramp_a_latency", cap_a_t[0] - acc_t, 2);
         chk("ramp_a_period",  cap_a_t[1] - cap_a_t[0], 4);
      end else begin
         chk("ramp_a_pulses", longint'(cap_a_t.size()), 4);
      end

      // Gapped valid on A.
      rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
      clear_caps();
      for (int k = 0; k < 16; k++) begin
         a_vi = ((k % 2) == 0); a_di = 19'(k / 2);
         tick();
      end
      idle_all();
      repeat (6) tick();
      w_a = '{3, 4};
      chk_seq("gapped_a", cap_a, w_a);
      if (cap_a_t.size() == 2) chk("gapped_a_period", cap_a_t[1] - cap_a_t[0], 8);

      // Reset after a partial group: the next run matches a fresh start.
      clear_caps();
      for (int k = 0; k < 2; k++) begin
         a_vi = 1'b1; a_di = 19'(k);
         tick();
      end
      idle_all();
      rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         a_vi = 1'b1; a_di = 19'(k);
         tick();
      end
      idle_all();
      repeat (6) tick();
      chk_seq("midreset_a", cap_a, w_a);

      // Randomised traffic with one reset in the middle.
      for (int k = 0; k < 1500; k++) begin
         rst_n = !(k >= 700 && k < 702);
         a_vi = ($urandom_range(0, 9) < 6); a_di = 19'($urandom);
         b_vi = ($urandom_range(0, 9) < 7); b_di = 8'($urandom);
         c_vi = ($urandom_range(0, 9) < 8); c_di = 12'($urandom);
         tick();
      end
      rst_n = 1'b1;
      idle_all();
      repeat (6) tick();
      run_chk = 1'b0;
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
